// File: rtl/fetch_sequencer_if.sv
// Signal bundle between the fetch sequencer and its neighbours: pipeline control,
// BTB, fetch memory and the three-port instruction buffer.
interface fetch_sequencer_if;
    logic        flush_i;
    logic [31:0] flush_address_i;
    logic        halt_i;
    logic        fetch_request_o;
    logic [31:0] fetch_address_o;
    logic        fetch_ready_i;
    logic        fetch_valid_i;
    logic [31:0] fetch_instruction_i;
    logic        btb_hit_i;
    logic        btb_taken_i;
    logic [31:0] btb_target_i;
    logic        buf_flush_o;
    logic        buf_write_address_o;
    logic        buf_write_speculative_o;
    logic        buf_write_instruction_o;
    logic        buf_speculative_o;
    logic        buf_taken_o;
    logic        buf_full_i;

    // The instruction word goes straight from memory to the buffer; the sequencer
    // only produces its write strobe.
    modport master (
        input  flush_i, flush_address_i, halt_i,
        input  fetch_ready_i, fetch_valid_i,
        input  btb_hit_i, btb_taken_i, btb_target_i,
        input  buf_full_i,
        output fetch_request_o, fetch_address_o,
        output buf_flush_o, buf_write_address_o, buf_write_speculative_o,
        output buf_write_instruction_o, buf_speculative_o, buf_taken_o
    );

    modport slave (
        output flush_i, flush_address_i, halt_i,
        output fetch_ready_i, fetch_valid_i, fetch_instruction_i,
        output btb_hit_i, btb_taken_i, btb_target_i,
        output buf_full_i,
        input  fetch_request_o, fetch_address_o,
        input  buf_flush_o, buf_write_address_o, buf_write_speculative_o,
        input  buf_write_instruction_o, buf_speculative_o, buf_taken_o
    );
endinterface

// File: rtl/fetch_sequencer.sv
// Front-end fetch controller: picks the next PC, issues memory fetches and keeps the
// address, speculative and instruction write ports of the instruction buffer aligned.
module fetch_sequencer #(
    parameter logic [31:0] RESET_VECTOR    = 32'h0000_0000,
    parameter int          MAX_OUTSTANDING = 4
) (
    input  logic               clk_i,
    input  logic               rst_i,
    fetch_sequencer_if.master  bus
);
    localparam int CW = $clog2(MAX_OUTSTANDING) + 1;
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTSTANDING);

    typedef enum logic [1:0] {BOOT, FETCH, HOLD} state_t;

    state_t        r_state;
    logic [31:0]   r_pc;
    logic          r_btb_valid;
    logic [CW-1:0] r_outstanding;
    logic [CW-1:0] r_discard;

    logic          w_redirect;
    logic          w_request;
    logic          w_issue;
    logic          w_resp;
    logic [31:0]   w_addr;

    // BOOT behaves exactly like a flush to the reset vector.
    assign w_redirect = (r_state == BOOT) | bus.flush_i;
    assign w_request  = ~rst_i & ((r_state != HOLD) | w_redirect) & ~bus.buf_full_i
                      & (r_outstanding < MAX_CNT);
    assign w_issue    = w_request & bus.fetch_ready_i;
    assign w_resp     = bus.fetch_valid_i & (r_outstanding != '0);

    always_comb begin
        w_addr = r_pc;
        if (r_state == BOOT)
            w_addr = RESET_VECTOR;
        else if (bus.flush_i)
            w_addr = bus.flush_address_i;
        else if (r_btb_valid & bus.btb_hit_i & bus.btb_taken_i)
            w_addr = bus.btb_target_i;
    end

    assign bus.fetch_request_o         = w_request;
    assign bus.fetch_address_o         = w_addr;
    assign bus.buf_flush_o             = ~rst_i & w_redirect;
    assign bus.buf_write_address_o     = w_issue;
    assign bus.buf_write_speculative_o = ~rst_i & (w_redirect ? w_issue : r_btb_valid);
    assign bus.buf_speculative_o       = ~w_redirect & bus.btb_hit_i;
    assign bus.buf_taken_o             = ~w_redirect & bus.btb_hit_i & bus.btb_taken_i;
    assign bus.buf_write_instruction_o = ~rst_i & w_resp & (r_discard == '0) & ~w_redirect;

    // pc keeps an unissued redirect target so it is fetched once issue becomes possible.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state       <= BOOT;
            r_pc          <= RESET_VECTOR;
            r_btb_valid   <= 1'b0;
            r_outstanding <= '0;
            r_discard     <= '0;
        end else begin
            r_state     <= bus.halt_i ? HOLD : FETCH;
            r_pc        <= w_issue ? (w_addr + 32'd4) : w_addr;
            r_btb_valid <= w_issue & ~w_redirect;
            if (w_redirect) begin
                r_discard     <= r_outstanding - CW'(w_resp);
                r_outstanding <= r_outstanding - CW'(w_resp) + CW'(w_issue);
            end else begin
                r_outstanding <= r_outstanding + CW'(w_issue) - CW'(w_resp);
                if (w_resp && (r_discard != '0))
                    r_discard <= r_discard - CW'(1);
            end
        end
    end
endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed scenarios followed by random
// traffic, all compared against a queue-based model of in-flight fetches.
module tb_fetch_sequencer;
    localparam logic [31:0] RV   = 32'h0000_0000;
    localparam int          MAXO = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fetch_sequencer_if bus();

    fetch_sequencer #(.RESET_VECTOR(RV), .MAX_OUTSTANDING(MAXO)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Model: each in-flight fetch is a queue entry, 1 = live, 0 = stale after a flush.
    bit          m_boot;
    bit          m_hold;
    bit          m_btb_pend;
    logic [31:0] m_pc;
    bit          m_q[$];

    // Last observed DUT outputs, for directed checks against constants.
    logic        o_req, o_flush, o_sw, o_iw, o_spec, o_taken;
    logic [31:0] o_addr;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit flush, input logic [31:0] faddr, input bit halt,
                         input bit ready, input bit valid, input bit hit, input bit taken,
                         input logic [31:0] target, input bit full);
        bus.flush_i             = flush;
        bus.flush_address_i     = faddr;
        bus.halt_i              = halt;
        bus.fetch_ready_i       = ready;
        bus.fetch_valid_i       = valid;
        bus.fetch_instruction_i = $urandom;
        bus.btb_hit_i           = hit;
        bus.btb_taken_i         = taken;
        bus.btb_target_i        = target;
        bus.buf_full_i          = full;
    endtask

    task automatic do_reset(input int cycles);
        for (int k = 0; k < cycles; k++) begin
            @(posedge clk); #1;
            rst = 1'b1;
            drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
            #3;
            check("rst_req",   32'(bus.fetch_request_o), 32'h0);
            check("rst_flush", 32'(bus.buf_flush_o), 32'h0);
            check("rst_wa",    32'(bus.buf_write_address_o), 32'h0);
            check("rst_ws",    32'(bus.buf_write_speculative_o), 32'h0);
            check("rst_wi",    32'(bus.buf_write_instruction_o), 32'h0);
        end
        m_boot = 1'b1; m_hold = 1'b0; m_btb_pend = 1'b0; m_pc = RV;
        m_q.delete();
        $display("[TB] t=%0t reset", $time);
    endtask

    task automatic step(input bit flush, input logic [31:0] faddr, input bit halt,
                        input bit ready, input bit valid, input bit hit, input bit taken,
                        input logic [31:0] target, input bit full);
        bit          redirect, req, iss, sw, iw;
        logic [31:0] addr;
        @(posedge clk); #1;
        rst = 1'b0;
        drive(flush, faddr, halt, ready, valid, hit, taken, target, full);
        #3;
        redirect = m_boot | flush;
        req  = (!m_hold || redirect) && !full && (m_q.size() < MAXO);
        iss  = req & ready;
        addr = m_boot ? RV : flush ? faddr : (m_btb_pend && hit && taken) ? target : m_pc;
        sw   = redirect ? iss : m_btb_pend;
        iw   = valid && (m_q.size() > 0) && m_q[0] && !redirect;

        o_req = bus.fetch_request_o;  o_addr = bus.fetch_address_o;
        o_flush = bus.buf_flush_o;    o_sw = bus.buf_write_speculative_o;
        o_iw = bus.buf_write_instruction_o;
        o_spec = bus.buf_speculative_o; o_taken = bus.buf_taken_o;

        check("req",   32'(o_req), 32'(req));
        check("addr",  o_addr, addr);
        check("flush", 32'(o_flush), 32'(redirect));
        check("wa",    32'(bus.buf_write_address_o), 32'(iss));
        check("ws",    32'(o_sw), 32'(sw));
        check("wi",    32'(o_iw), 32'(iw));
        if (sw) begin
            check("spec",  32'(o_spec),  redirect ? 32'h0 : 32'(hit));
            check("taken", 32'(o_taken), redirect ? 32'h0 : 32'(hit & taken));
        end
        if (iss || iw)
            $display("[TB] t=%0t issue=%0d addr=%h flush=%0d spec_wr=%0d instr_wr=%0d inflight=%0d",
                     $time, iss, addr, redirect, sw, iw, m_q.size());

        if (valid && m_q.size() > 0) void'(m_q.pop_front());
        if (redirect) foreach (m_q[i]) m_q[i] = 1'b0;
        if (iss) m_q.push_back(1'b1);
        m_pc       = iss ? addr + 32'd4 : addr;
        m_btb_pend = iss & !redirect;
        m_hold     = halt;
        m_boot     = 1'b0;
    endtask

    task automatic idle(input bit ready, input bit valid);
        step(1'b0, 32'h0, 1'b0, ready, valid, 1'b0, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic drain();
        for (int k = 0; k < 20 && m_q.size() > 0; k++) idle(1'b0, 1'b1);
        check("drain_bound", 32'(m_q.size()), 32'h0);
    endtask

    initial begin
        int cnt;
        bit halt_r;
        rst = 1'b1;
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        do_reset(2);

        // Boot sequence and BTB redirect
        idle(1'b1, 1'b0); check("boot_addr", o_addr, 32'h0); check("boot_flush", 32'(o_flush), 32'h1);
        idle(1'b1, 1'b0); check("seq_addr1", o_addr, 32'h4); check("seq_flush", 32'(o_flush), 32'h0);
        idle(1'b1, 1'b0); check("seq_addr2", o_addr, 32'h8);
        step(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h100, 1'b0);
        check("btb_addr", o_addr, 32'h100); check("btb_spec", {30'h0, o_spec, o_taken}, 32'h3);
        idle(1'b1, 1'b1); check("btb_next", o_addr, 32'h104);

        // Flush with three in flight and a response in the flush cycle
        drain();
        for (int k = 0; k < 3; k++) idle(1'b1, 1'b0);
        step(1'b1, 32'h200, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        check("flush_addr", o_addr, 32'h200); check("flush_wi", 32'(o_iw), 32'h0);
        idle(1'b0, 1'b1); check("stale1", 32'(o_iw), 32'h0);
        idle(1'b0, 1'b1); check("stale2", 32'(o_iw), 32'h0);
        idle(1'b0, 1'b1); check("live", 32'(o_iw), 32'h1);

        // Outstanding limit
        drain();
        cnt = 0;
        for (int k = 0; k < 6; k++) begin idle(1'b1, 1'b0); if (o_req === 1'b1) cnt++; end
        check("max_cnt", 32'(cnt), 32'(MAXO));
        idle(1'b1, 1'b1); check("max_resp_cyc", 32'(o_req), 32'h0);
        idle(1'b1, 1'b0); check("max_after", 32'(o_req), 32'h1);
        idle(1'b1, 1'b0); check("max_again", 32'(o_req), 32'h0);

        // Buffer full, halt, flush during HOLD
        drain();
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
            check("full_req", 32'(o_req), 32'h0);
        end
        idle(1'b1, 1'b1); check("full_resume", 32'(o_req), 32'h1);
        drain();
        step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        check("hold_req", 32'(o_req), 32'h0);
        step(1'b1, 32'h300, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        check("hold_flush_req", 32'(o_req), 32'h1); check("hold_flush_addr", o_addr, 32'h300);
        step(1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h500, 1'b0);
        check("hold_idle", 32'(o_req), 32'h0);

        // Randomized traffic, including occasional mid-run reset and address wrap
        halt_r = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 399) == 0) do_reset(1);
            if ($urandom_range(0, 19) == 0) halt_r = ~halt_r;
            step($urandom_range(0, 19) == 0,
                 ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'hFFFF_FFFC),
                 halt_r,
                 $urandom_range(0, 3) != 0,
                 $urandom_range(0, 9) < 4,
                 $urandom_range(0, 1) == 1,
                 $urandom_range(0, 1) == 1,
                 ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC),
                 $urandom_range(0, 9) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
